// File: rtl/adder_subtractor_serial.sv
// Digit-serial adder/subtractor.
// Processes DIGIT bits of each operand per clock, LSB first, and commits the
// full WIDTH-bit sum/difference, carry/borrow-out and signed overflow after
// N = WIDTH/DIGIT cycles. Subtraction is A + ~B + 1.
module adder_subtractor_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S_D,
  output logic             C_B_out,
  output logic             Overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state_q, state_d;

  // Operand shift registers; B is stored already conditionally inverted.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic [CNT_W-1:0] cnt;

  // Committed results.
  logic             done_q;
  logic [WIDTH-1:0] sd_q;
  logic             cb_q;
  logic             ov_q;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] res_next;
  logic             last;
  logic             accept;

  // Adds one digit of each operand plus the running carry; the top bit is
  // the carry into the next digit.
  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] a,
                                               input logic [DIGIT-1:0] b,
                                               input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  endfunction

  // Signed overflow: operands of equal sign producing a result of the other sign.
  function automatic logic overflow_flag(input logic a_s,
                                         input logic b_s,
                                         input logic s_s);
    return (a_s == b_s) && (s_s != a_s);
  endfunction

  // Digit adder and result-register shift value.
  always_comb begin
    dsum     = digit_add(a_sr[DIGIT-1:0], b_sr[DIGIT-1:0], carry);
    res_next = (res_sr >> DIGIT) |
               (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  // The final RUN cycle commits the result and may also accept the next
  // request so back-to-back operations run without an idle cycle.
  always_comb begin
    last   = (state_q == RUN) && (cnt == CNT_W'(N - 1));
    accept = start && ((state_q == IDLE) || last);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_d = start ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy     = (state_q == RUN);
    done     = done_q;
    S_D      = sd_q;
    C_B_out  = cb_q;
    Overflow = ov_q;
  end

  // Digit counter, done pulse and committed results; all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      done_q <= 1'b0;
      sd_q   <= '0;
      cb_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        cnt <= '0;
      end else if (state_q == RUN) begin
        cnt <= last ? '0 : cnt + CNT_W'(1);
      end
      if (last) begin
        sd_q <= res_next;
        cb_q <= dsum[DIGIT];
        ov_q <= overflow_flag(a_msb, b_msb, res_next[WIDTH-1]);
      end
    end
  end

  // Operand capture and serial datapath; a reset is not needed here because
  // nothing is committed without passing through the counter first.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sr   <= A;
      b_sr   <= B ^ {WIDTH{Mode}};
      carry  <= Mode;
      a_msb  <= A[WIDTH-1];
      b_msb  <= B[WIDTH-1] ^ Mode;
      res_sr <= '0;
    end else if (state_q == RUN) begin
      a_sr   <= a_sr >> DIGIT;
      b_sr   <= b_sr >> DIGIT;
      carry  <= dsum[DIGIT];
      res_sr <= res_next;
    end
  end

endmodule
